// File: rtl/reg_file_sb.sv
// Integer register file with write-back bypass and a per-register pending-write scoreboard.
// Decode reads two operands and stalls on RAW hazards until the producer retires through WB.
module reg_file_sb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_rf_wr,
    input  logic [AW-1:0]   i_wr_addr,
    input  logic [XLEN-1:0] i_wr_data,
    input  logic [AW-1:0]   i_rs1_addr,
    input  logic [AW-1:0]   i_rs2_addr,
    output logic [XLEN-1:0] o_rs1_data,
    output logic [XLEN-1:0] o_rs2_data,
    input  logic            i_issue_valid,
    input  logic [AW-1:0]   i_issue_rd,
    output logic            o_rs1_busy,
    output logic            o_rs2_busy,
    output logic [5:0]      o_busy_cnt
);

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] r_busy;
    logic [5:0]       r_busy_cnt;

    logic             w_wr_en;
    logic             w_rs1_hit;
    logic             w_rs2_hit;
    logic [NREGS-1:0] w_busy_nxt;
    logic [5:0]       w_cnt_nxt;

    assign w_wr_en   = i_rf_wr && (i_wr_addr != '0);
    assign w_rs1_hit = i_rf_wr && (i_wr_addr == i_rs1_addr);
    assign w_rs2_hit = i_rf_wr && (i_wr_addr == i_rs2_addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[i_wr_addr] <= i_wr_data;
        end
    end

    // Set is applied after clear so a same-index issue (younger producer) wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wr_en) begin
            w_busy_nxt[i_wr_addr] = 1'b0;
        end
        if (i_issue_valid && (i_issue_rd != '0)) begin
            w_busy_nxt[i_issue_rd] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_comb begin
        w_cnt_nxt = '0;
        for (int i = 0; i < NREGS; i++) begin
            w_cnt_nxt = w_cnt_nxt + 6'(w_busy_nxt[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy     <= '0;
            r_busy_cnt <= '0;
        end else begin
            r_busy     <= w_busy_nxt;
            r_busy_cnt <= w_cnt_nxt;
        end
    end

    always_comb begin
        o_rs1_data = r_regs[i_rs1_addr];
        if (i_rs1_addr == '0) begin
            o_rs1_data = '0;
        end else if (w_rs1_hit) begin
            o_rs1_data = i_wr_data;
        end
    end

    always_comb begin
        o_rs2_data = r_regs[i_rs2_addr];
        if (i_rs2_addr == '0) begin
            o_rs2_data = '0;
        end else if (w_rs2_hit) begin
            o_rs2_data = i_wr_data;
        end
    end

    // A retiring write releases the stall in the same cycle it is bypassed.
    assign o_rs1_busy = r_busy[i_rs1_addr] & ~w_rs1_hit;
    assign o_rs2_busy = r_busy[i_rs2_addr] & ~w_rs2_hit;
    assign o_busy_cnt = r_busy_cnt;

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- 32x32 integer register file: the receiving end of the write-back stage's register write interface.
- Accepts WB's write enable and write data, plus the destination register index carried down the pipeline.
- Provides two read ports to Decode, with write-to-read bypass.
- Holds a per-register pending-write scoreboard so Decode can stall on RAW hazards until the producing instruction retires through WB.

Parameters:
- XLEN, 32, data width of each register
- NREGS, 32, number of architectural registers (index width = clog2(NREGS) = 5)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- i_rf_wr  input  1  write enable from WB
- i_wr_addr  input  5  destination register index of the retiring instruction
- i_wr_data  input  XLEN  write-back data from WB
- i_rs1_addr  input  5  read port 1 index
- i_rs2_addr  input  5  read port 2 index
- o_rs1_data  output  XLEN  read port 1 data
- o_rs2_data  output  XLEN  read port 2 data
- i_issue_valid  input  1  Decode issues an instruction that will write rd
- i_issue_rd  input  5  destination index of the issuing instruction
- o_rs1_busy  output  1  rs1 has an outstanding write
- o_rs2_busy  output  1  rs2 has an outstanding write
- o_busy_cnt  output  6  number of registers currently marked busy (0..31)

Behaviour:
- Reset (rst=1, asynchronous):
  - All registers clear to 0, all busy bits clear, o_busy_cnt=0.
  - Read outputs reflect zeroed storage combinationally; busy outputs are 0.
  - Reset asserted mid-operation discards any in-flight write and issue in that cycle.
- Write:
  - On posedge clk, when i_rf_wr=1 and i_wr_addr!=0, regs[i_wr_addr] <= i_wr_data.
  - Writes to x0 are ignored; x0 always reads 0.
- Read: combinational, zero latency.
  - o_rsN_data = 0 if i_rsN_addr==0.
  - Otherwise i_wr_data if i_rf_wr=1 and i_wr_addr==i_rsN_addr (same-cycle bypass).
  - Otherwise regs[i_rsN_addr].
- Scoreboard: busy[31:1] registers; busy[0] is constant 0.
  - Set: posedge with i_issue_valid=1 and i_issue_rd!=0 -> busy[i_issue_rd] <= 1.
  - Clear: posedge with i_rf_wr=1 and i_wr_addr!=0 -> busy[i_wr_addr] <= 0.
  - Same index set and cleared in the same cycle: set wins (the new producer is younger). Final busy=1, data is still written.
  - Different indices: both updates apply independently.
  - Set on an already-busy register: stays 1 (no counting of multiple producers).
  - Clear on a non-busy register: stays 0, write still performed.
- Busy outputs:
  - o_rsN_busy = busy[i_rsN_addr] & ~(i_rf_wr & (i_wr_addr==i_rsN_addr)).
  - A retiring write releases the stall in the same cycle, consistent with the bypass.
  - Busy is 0 for index 0.
- o_busy_cnt:
  - Registered population count of busy, updated every posedge.
  - Equals the number of set bits after that edge's updates.
  - Net change per cycle is -1, 0 or +1.
- Arithmetic: indices compared as unsigned 5-bit values. No other arithmetic beyond the popcount, which saturates naturally at 31.

Test Plan:
- Reset, no writes -> o_rs1_data=o_rs2_data=0 for every index 0..31; o_rs1_busy=0; o_busy_cnt=0.
- Write x5=0xDEADBEEF with i_rs1_addr=5 in the same cycle -> o_rs1_data=0xDEADBEEF that cycle (bypass). Next cycle with i_rf_wr=0 -> still 0xDEADBEEF from storage.
- Write x0=0x12345678, then read rs2=0 -> o_rs2_data=0. Issue with i_issue_rd=0 -> o_busy_cnt stays 0.
- Issue rd=7, then read rs1=7 -> o_rs1_busy=1, o_busy_cnt=1. Two cycles later WB writes x7=0xA5 with rs1=7 -> o_rs1_busy=0 and o_rs1_data=0xA5 that cycle; next cycle o_busy_cnt=0.
- Same cycle: issue rd=9 and WB writes x9=0x55 (x9 previously busy) -> after the edge busy[9]=1, regs[9]=0x55, o_busy_cnt unchanged.
- Issue rd=3,4,5 on consecutive cycles (o_busy_cnt=3), then assert rst asynchronously between edges -> o_busy_cnt=0, all busy=0, x3..x5 read 0 immediately.
